// File: rtl/aes_round_sequencer.sv
// Control FSM that walks one AES encryption through the SB/SR/MC/ARK units and strobes the state register.
// Optional per-stage WAIT timeout with sticky err: define AES_ROUND_SEQUENCER_TIMEOUT_EN.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS     = 10,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       sb_done,
    input  logic       sr_done,
    input  logic       mc_done,
    input  logic       ark_done,
    output logic       sb_start,
    output logic       sr_start,
    output logic       mc_start,
    output logic       ark_start,
    output logic [1:0] state_sel,
    output logic       state_load,
    output logic [3:0] round,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_LOAD,
        S_FIN,
        S_ERR
    } state_t;

    localparam logic [1:0] STG_SB  = 2'd0;
    localparam logic [1:0] STG_SR  = 2'd1;
    localparam logic [1:0] STG_MC  = 2'd2;
    localparam logic [1:0] STG_ARK = 2'd3;
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t     state_q, state_d;
    logic [1:0] stage_q, stage_d;
    logic [3:0] round_q, round_d;
    logic       seen_low_q, seen_low_d;
    logic       sel_done;
    logic       timeout_hit;

    // Only the unit owning the current stage is observed.
    always_comb begin
        sel_done = 1'b0;
        case (stage_q)
            STG_SB:  sel_done = sb_done;
            STG_SR:  sel_done = sr_done;
            STG_MC:  sel_done = mc_done;
            default: sel_done = ark_done;
        endcase
    end

`ifdef AES_ROUND_SEQUENCER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tcnt_q, tcnt_d;

    always_comb begin
        tcnt_d = tcnt_q;
        if (state_q == S_ISSUE)
            tcnt_d = 8'd0;
        else if (state_q == S_WAIT)
            tcnt_d = tcnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tcnt_q <= 8'd0;
        else
            tcnt_q <= tcnt_d;
    end

    assign timeout_hit = (tcnt_q == TIMEOUT_LAST);
    assign err         = (state_q == S_ERR);
`else
    // Without the timeout, TIMEOUT_CYCLES is accepted but has no effect.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_unused
    end
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            stage_q    <= STG_SB;
            round_q    <= 4'd0;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            round_q    <= round_d;
            seen_low_q <= seen_low_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        round_d    = round_q;
        seen_low_d = seen_low_q;
        case (state_q)
            S_IDLE, S_ERR: begin
                if (go) begin
                    state_d = S_ISSUE;
                    stage_d = STG_ARK;
                    round_d = 4'd0;
                end
            end
            S_ISSUE: begin
                state_d    = S_WAIT;
                seen_low_d = 1'b0;
            end
            S_WAIT: begin
                // A done level still high from the previous job must drop before it counts.
                if (seen_low_q && sel_done)
                    state_d = S_LOAD;
                else if (timeout_hit)
                    state_d = S_ERR;
                else
                    seen_low_d = seen_low_q | ~sel_done;
            end
            S_LOAD: begin
                state_d = S_ISSUE;
                case (stage_q)
                    STG_SB: stage_d = STG_SR;
                    STG_SR: stage_d = (round_q == LAST_ROUND) ? STG_ARK : STG_MC;
                    STG_MC: stage_d = STG_ARK;
                    default: begin
                        if (round_q == LAST_ROUND) begin
                            state_d = S_FIN;
                        end else begin
                            stage_d = STG_SB;
                            round_d = round_q + 4'd1;
                        end
                    end
                endcase
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sb_start   = 1'b0;
        sr_start   = 1'b0;
        mc_start   = 1'b0;
        ark_start  = 1'b0;
        state_load = 1'b0;
        state_sel  = 2'd0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_ISSUE: begin
                busy = 1'b1;
                case (stage_q)
                    STG_SB:  sb_start  = 1'b1;
                    STG_SR:  sr_start  = 1'b1;
                    STG_MC:  mc_start  = 1'b1;
                    default: ark_start = 1'b1;
                endcase
            end
            S_WAIT: busy = 1'b1;
            S_LOAD: begin
                busy       = 1'b1;
                state_load = 1'b1;
                state_sel  = stage_q;
            end
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end

    assign round = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: a 10-round and a 14-round instance driven by behavioural unit models.
module tb_aes_round_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       go0, go1;
    logic [3:0] st0, st1, dn0, dn1;
    logic [1:0] sel0, sel1;
    logic       load0, load1, busy0, busy1, fin0, fin1, err0, err1;
    logic [3:0] rnd0, rnd1;

    int total = 0;
    int bad   = 0;

    // Unit models, index [dut][unit] with unit 0=SB 1=SR 2=MC 3=ARK.
    // mode 0: done low only in the first cycle after start; 1: done low forever after start;
    // 2: done high 6 cycles, low 2, then high.
    logic [3:0] ph   [2][4];
    int         mode [2][4];
    logic       sb_kill;

    function automatic logic mdone(input int m, input logic [3:0] p);
        case (m)
            1:       return p == 4'd0;
            2:       return !(p >= 4'd7 && p <= 4'd8);
            default: return p != 4'd1;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 2; d++)
                for (int u = 0; u < 4; u++)
                    ph[d][u] <= 4'd0;
        end else begin
            for (int d = 0; d < 2; d++)
                for (int u = 0; u < 4; u++)
                    if (d == 0 ? st0[u] : st1[u])
                        ph[d][u] <= 4'd1;
                    else if (ph[d][u] != 4'd0 && ph[d][u] != 4'd15)
                        ph[d][u] <= ph[d][u] + 4'd1;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_dn
        assign dn0[g] = mdone(mode[0][g], ph[0][g]) & !(g == 0 && sb_kill);
        assign dn1[g] = mdone(mode[1][g], ph[1][g]);
    end

    aes_round_sequencer #(.NUM_ROUNDS(10), .TIMEOUT_CYCLES(20)) dut0 (
        .clk(clk), .reset(reset), .go(go0),
        .sb_done(dn0[0]), .sr_done(dn0[1]), .mc_done(dn0[2]), .ark_done(dn0[3]),
        .sb_start(st0[0]), .sr_start(st0[1]), .mc_start(st0[2]), .ark_start(st0[3]),
        .state_sel(sel0), .state_load(load0), .round(rnd0),
        .busy(busy0), .done(fin0), .err(err0)
    );

    aes_round_sequencer #(.NUM_ROUNDS(14)) dut1 (
        .clk(clk), .reset(reset), .go(go1),
        .sb_done(dn1[0]), .sr_done(dn1[1]), .mc_done(dn1[2]), .ark_done(dn1[3]),
        .sb_start(st1[0]), .sr_start(st1[1]), .mc_start(st1[2]), .ark_start(st1[3]),
        .state_sel(sel1), .state_load(load1), .round(rnd1),
        .busy(busy1), .done(fin1), .err(err1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Expected state_sel of load number i for a run of nr rounds.
    function automatic int exp_sel(input int i, input int nr);
        int j;
        if (i == 0) return 3;
        j = i - 1;
        if (j < 4 * (nr - 1)) return j % 4;
        j = j - 4 * (nr - 1);
        return (j == 2) ? 3 : j;
    endfunction

    task automatic pulse_go0;
        go0 = 1'b1;
        tick();
        go0 = 1'b0;
    endtask

    // One full 10-round run on dut0; first sample is cycle 1 after the go edge.
    task automatic check_full_run(input string nm);
        int loads = 0, mc10 = 0, fincyc = -1;
        logic busy_at_fin = 1'b1;
        pulse_go0();
        total++;
        if (!(st0[3] === 1'b1 && busy0 === 1'b1 && rnd0 === 4'd0)) begin
            bad++;
            $display("FAIL %s_first_issue got ark_start=%b busy=%b round=%0d want 1 1 0", nm, st0[3], busy0, rnd0);
        end
        for (int k = 1; k <= 200; k++) begin
            if (load0) begin
                total++;
                if (loads >= 40 || int'(sel0) != exp_sel(loads, 10)) begin
                    bad++;
                    $display("FAIL %s_sel load=%0d got=%0d want=%0d", nm, loads, sel0, exp_sel(loads, 10));
                end
                loads++;
            end
            if (st0[2] && rnd0 == 4'd10) mc10++;
            if (fin0) begin
                fincyc = k;
                busy_at_fin = busy0;
                break;
            end
            tick();
        end
        total++;
        if (loads != 40) begin bad++; $display("FAIL %s_loads got=%0d want=40", nm, loads); end
        total++;
        if (mc10 != 0) begin bad++; $display("FAIL %s_mc_final got=%0d want=0", nm, mc10); end
        total++;
        if (fincyc != 161) begin bad++; $display("FAIL %s_done_cycle got=%0d want=161", nm, fincyc); end
        total++;
        if (busy_at_fin !== 1'b0) begin bad++; $display("FAIL %s_busy_at_done got=%b want=0", nm, busy_at_fin); end
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2;
        total++;
        if ({st0, load0, sel0, rnd0, busy0, fin0, err0} !== 14'd0) begin
            bad++;
            $display("FAIL reset_dut0 got=%h want=0", {st0, load0, sel0, rnd0, busy0, fin0, err0});
        end
        total++;
        if ({st1, load1, sel1, rnd1, busy1, fin1, err1} !== 14'd0) begin
            bad++;
            $display("FAIL reset_dut1 got=%h want=0", {st1, load1, sel1, rnd1, busy1, fin1, err1});
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_full;
        check_full_run("full");
    endtask

    task automatic test_reset_mid;
        int k;
        mode[0][2] = 0;
        pulse_go0();
        for (k = 0; k < 300 && rnd0 != 4'd5; k++) tick();
        total++;
        if (rnd0 !== 4'd5) begin bad++; $display("FAIL midrst_reach_r5 got=%0d want=5", rnd0); end
        mode[0][2] = 1;
        for (k = 0; k < 20 && !st0[2]; k++) tick();
        tick();
        tick();
        tick();
        total++;
        if (!(busy0 === 1'b1 && load0 === 1'b0 && rnd0 === 4'd5)) begin
            bad++;
            $display("FAIL midrst_stalled got busy=%b load=%b round=%0d want 1 0 5", busy0, load0, rnd0);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({st0, load0, sel0, rnd0, busy0, fin0, err0} !== 14'd0) begin
            bad++;
            $display("FAIL midrst_outputs got=%h want=0", {st0, load0, sel0, rnd0, busy0, fin0, err0});
        end
        tick();
        reset = 1'b0;
        mode[0][2] = 0;
        tick();
        check_full_run("after_reset");
    endtask

    task automatic test_stale_done;
        int k;
        logic early = 1'b0;
        mode[0][2] = 2;
        pulse_go0();
        for (k = 1; k < 40 && !st0[2]; k++) tick();
        total++;
        if (st0[2] !== 1'b1 || k != 13) begin bad++; $display("FAIL stale_mc_issue got cycle=%0d want=13", k); end
        for (int j = 1; j <= 9; j++) begin
            tick();
            if (load0 !== 1'b0) early = 1'b1;
        end
        total++;
        if (early) begin bad++; $display("FAIL stale_early_load got=1 want=0"); end
        tick();
        total++;
        if (load0 !== 1'b1 || sel0 !== 2'd2) begin
            bad++;
            $display("FAIL stale_load got load=%b sel=%0d want 1 2", load0, sel0);
        end
        mode[0][2] = 0;
        reset_pulse();
    endtask

    task automatic test_ignored_inputs;
        int arkcnt = 0, loads = 0, fincyc = -1, mc_c = -10;
        logic a162 = 1'b1, a163 = 1'b0;
        go0 = 1'b1;
        tick();
        for (int k = 1; k <= 163; k++) begin
            if (st0[3] && k <= 161) arkcnt++;
            if (load0) loads++;
            if (fin0 && fincyc < 0) fincyc = k;
            if (k == 162) a162 = st0[3];
            if (k == 163) a163 = st0[3];
            if (st0[2]) mc_c = k;
            if (k == mc_c + 1) sb_kill = 1'b1;
            else if (k == mc_c + 2) sb_kill = 1'b0;
            if (k < 163) tick();
        end
        sb_kill = 1'b0;
        go0 = 1'b0;
        total++;
        if (fincyc != 161) begin bad++; $display("FAIL ign_done_cycle got=%0d want=161", fincyc); end
        total++;
        if (arkcnt != 11) begin bad++; $display("FAIL ign_ark_starts got=%0d want=11", arkcnt); end
        total++;
        if (loads != 40) begin bad++; $display("FAIL ign_loads got=%0d want=40", loads); end
        total++;
        if (a162 !== 1'b0 || a163 !== 1'b1) begin
            bad++;
            $display("FAIL ign_restart got c162=%b c163=%b want 0 1", a162, a163);
        end
        reset_pulse();
    endtask

    task automatic test_rounds14;
        int loads = 0, maxr = 0, mcs = 0, fincyc = -1;
        go1 = 1'b1;
        tick();
        go1 = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            if (load1) loads++;
            if (int'(rnd1) > maxr) maxr = int'(rnd1);
            if (st1[2]) mcs++;
            if (fin1) begin fincyc = k; break; end
            tick();
        end
        total++;
        if (loads != 56) begin bad++; $display("FAIL r14_loads got=%0d want=56", loads); end
        total++;
        if (maxr != 14) begin bad++; $display("FAIL r14_max_round got=%0d want=14", maxr); end
        total++;
        if (mcs != 13) begin bad++; $display("FAIL r14_mc_starts got=%0d want=13", mcs); end
        total++;
        if (fincyc != 225) begin bad++; $display("FAIL r14_done_cycle got=%0d want=225", fincyc); end
        tick();
    endtask

    task automatic test_timeout;
        mode[0][3] = 1;
        pulse_go0();
`ifdef AES_ROUND_SEQUENCER_TIMEOUT_EN
        for (int k = 1; k < 21; k++) tick();
        total++;
        if (err0 !== 1'b0 || busy0 !== 1'b1) begin
            bad++;
            $display("FAIL to_before got err=%b busy=%b want 0 1", err0, busy0);
        end
        tick();
        total++;
        if ({err0, busy0, fin0, st0, load0} !== 8'b1000_0000) begin
            bad++;
            $display("FAIL to_err got=%b want=10000000", {err0, busy0, fin0, st0, load0});
        end
        for (int k = 0; k < 5; k++) tick();
        total++;
        if (err0 !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b want=1", err0); end
        mode[0][3] = 0;
        check_full_run("to_resume");
        total++;
        if (err0 !== 1'b0) begin bad++; $display("FAIL to_err_cleared got=%b want=0", err0); end
`else
        for (int k = 1; k < 40; k++) tick();
        total++;
        if (err0 !== 1'b0 || busy0 !== 1'b1) begin
            bad++;
            $display("FAIL to_disabled got err=%b busy=%b want 0 1", err0, busy0);
        end
        mode[0][3] = 0;
        reset_pulse();
`endif
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int u = 0; u < 4; u++)
                mode[d][u] = 0;
        sb_kill = 1'b0;
        go0 = 1'b0;
        go1 = 1'b0;
        test_reset();
        test_full();
        test_reset_mid();
        test_stale_done();
        test_ignored_inputs();
        test_rounds14();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
